// File: rtl/ev_ts_pkg.sv
// Shared types and defaults for the event-timestamper front end.
package ev_ts_pkg;
   localparam int ID_W_DEF = 3;
   localparam int TS_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_FREE,
      ST_PEND_S,
      ST_RUN,
      ST_PEND_E,
      ST_DONE
   } id_state_e;
endpackage

// File: rtl/ev_ts_scheduler_rr_arb.sv
// Round-robin arbiter: one-hot grant; after an accepted grant the priority
// starts at the slot just past the winner.
module rr_arb #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);
   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr_q, ptr_d;
   int            idx_c;
   int            win_c;
   logic          found_c;

   always_comb begin
      gnt     = '0;
      ptr_d   = ptr_q;
      idx_c   = 0;
      win_c   = 0;
      found_c = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx_c = (int'(ptr_q) + k) % N;
         if (!found_c && req[idx_c]) begin
            found_c = 1'b1;
            win_c   = idx_c;
         end
      end
      if (found_c) begin
         gnt[win_c] = 1'b1;
         if (advance) ptr_d = PW'((win_c + 1) % N);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/ev_ts_scheduler.sv
// Shares one event_timestamper between NREQ requesters: allocates IDs,
// arbitrates START/END, tracks per-ID lifecycle and tags results with owner.
//
// state     | meaning
// FREE      | ID unallocated, eligible for the next start grant
// PEND_S    | granted, start waiting in the issue register for the timestamper
// RUN       | start accepted by the timestamper, owner may end it
// PEND_E    | end accepted, waiting in the end issue register
// DONE      | end accepted by the timestamper, waiting for its result
module ev_ts_scheduler
   import ev_ts_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = ID_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_start_valid,
   output logic [NREQ-1:0]            req_start_ready,
   output logic [ID_W-1:0]            req_start_id,
   input  logic [NREQ-1:0]            req_end_valid,
   input  logic [NREQ*ID_W-1:0]       req_end_id,
   output logic [NREQ-1:0]            req_end_ready,
   output logic                       ts_start_valid,
   input  logic                       ts_start_ready,
   output logic [ID_W-1:0]            ts_start_id,
   output logic                       ts_end_valid,
   input  logic                       ts_end_ready,
   output logic [ID_W-1:0]            ts_end_id,
   input  logic                       ts_out_valid,
   output logic                       ts_out_ready,
   input  logic [ID_W-1:0]            ts_out_id,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [$clog2(NREQ)-1:0]    res_owner,
   output logic                       err_bad_end,
   output logic [ID_W:0]              active_cnt
);
   localparam int OWN_W = $clog2(NREQ);
   localparam int NID   = 2 ** ID_W;

   id_state_e        state_q [NID];
   id_state_e        state_d [NID];
   logic [OWN_W-1:0] owner_q [NID];
   logic [OWN_W-1:0] owner_d [NID];

   logic             run_q, s_full_q, s_full_d, e_full_q, e_full_d, err_q, err_d;
   logic [ID_W-1:0]  s_id_q, s_id_d, e_id_q, e_id_d;
   logic [ID_W:0]    cnt_q, cnt_d;

   logic [NREQ-1:0]  s_req, s_gnt, e_req, e_gnt;
   logic [ID_W-1:0]  alloc_id, e_id;
   logic [OWN_W-1:0] s_owner, e_owner;
   logic             any_free, s_hs, e_legal, s_done, e_done, res_hs, free_hit;

   // Lowest-index FREE ID from the registered state, so a just-freed ID waits a cycle.
   always_comb begin
      any_free = 1'b0;
      alloc_id = '0;
      for (int i = NID - 1; i >= 0; i--) begin
         if (state_q[i] == ST_FREE) begin
            any_free = 1'b1;
            alloc_id = ID_W'(i);
         end
      end
   end

   assign s_req = req_start_valid & {NREQ{run_q && any_free && !s_full_q}};
   assign e_req = req_end_valid & {NREQ{run_q && !e_full_q}};
   assign s_hs  = |s_gnt;

   rr_arb #(.N(NREQ)) u_start_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (s_req),
      .advance (s_hs),
      .gnt     (s_gnt)
   );

   rr_arb #(.N(NREQ)) u_end_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (e_req),
      .advance (|e_gnt),
      .gnt     (e_gnt)
   );

   always_comb begin
      s_owner = '0;
      e_owner = '0;
      e_id    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (s_gnt[i]) s_owner = OWN_W'(i);
         if (e_gnt[i]) begin
            e_owner = OWN_W'(i);
            e_id    = req_end_id[i*ID_W +: ID_W];
         end
      end
   end

   assign e_legal  = (|e_gnt) && (state_q[e_id] == ST_RUN) && (owner_q[e_id] == e_owner);
   assign s_done   = s_full_q && ts_start_ready;
   assign e_done   = e_full_q && ts_end_ready;
   assign res_hs   = run_q && ts_out_valid && res_ready;
   assign free_hit = res_hs && (state_q[ts_out_id] == ST_DONE);

   // Each transition below acts on an ID in a distinct state, so they never collide.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      s_full_d = s_full_q;
      s_id_d   = s_id_q;
      e_full_d = e_full_q;
      e_id_d   = e_id_q;
      cnt_d    = cnt_q;
      err_d    = (|e_gnt) && !e_legal;
      if (s_done) begin
         state_d[s_id_q] = ST_RUN;
         s_full_d        = 1'b0;
      end
      if (s_hs) begin
         state_d[alloc_id] = ST_PEND_S;
         owner_d[alloc_id] = s_owner;
         s_full_d          = 1'b1;
         s_id_d            = alloc_id;
      end
      if (e_done) begin
         state_d[e_id_q] = ST_DONE;
         e_full_d        = 1'b0;
      end
      if (e_legal) begin
         state_d[e_id] = ST_PEND_E;
         e_full_d      = 1'b1;
         e_id_d        = e_id;
      end
      if (free_hit) state_d[ts_out_id] = ST_FREE;
      if (s_hs && !free_hit)      cnt_d = cnt_q + 1'b1;
      else if (!s_hs && free_hit) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NID; i++) begin
            state_q[i] <= ST_FREE;
            owner_q[i] <= '0;
         end
         run_q    <= 1'b0;
         s_full_q <= 1'b0;
         s_id_q   <= '0;
         e_full_q <= 1'b0;
         e_id_q   <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         run_q    <= 1'b1;
         s_full_q <= s_full_d;
         s_id_q   <= s_id_d;
         e_full_q <= e_full_d;
         e_id_q   <= e_id_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign req_start_ready = s_gnt;
   assign req_start_id    = alloc_id;
   assign req_end_ready   = e_gnt;
   assign ts_start_valid  = s_full_q;
   assign ts_start_id     = s_id_q;
   assign ts_end_valid    = e_full_q;
   assign ts_end_id       = e_id_q;
   assign res_valid       = ts_out_valid && run_q;
   assign ts_out_ready    = res_ready && run_q;
   assign res_owner       = owner_q[ts_out_id];
   assign err_bad_end     = err_q;
   assign active_cnt      = cnt_q;
endmodule
